// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity receiver: FSM state encoding
// and the parity-sense constants used for the ODD parameter.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } rx_state_e;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

endpackage : parity_pkg

// File: rtl/parity_checker_rx.sv
// Serial frame receiver: collects DATA_W bits LSB first plus one parity bit,
// then holds the word and its parity verdict until the consumer takes it.
module parity_checker_rx
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD    = PARITY_EVEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic              s_bit,
  input  logic              s_start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity_err,
  output logic              abort,
  output logic              overrun
);

  localparam int   CNT_W   = $clog2(DATA_W + 1);
  localparam logic ODD_BIT = (ODD == PARITY_ODD);

  rx_state_e         state_q;
  logic [CNT_W-1:0]  count_q;
  logic              acc_q;
  logic [DATA_W-1:0] data_q;
  logic              outValid_q;
  logic              parityErr_q;
  logic              abort_q;
  logic              overrun_q;

  logic [DATA_W-1:0] firstWord;
  logic [DATA_W-1:0] bitMask;
  logic              startBit;

  assign startBit  = s_valid && s_start;
  assign firstWord = {{(DATA_W-1){1'b0}}, s_bit};
  assign bitMask   = firstWord << count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= 1'b0;
      data_q      <= '0;
      outValid_q  <= 1'b0;
      parityErr_q <= 1'b0;
      abort_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (startBit) begin
            data_q  <= firstWord;
            count_q <= CNT_W'(1);
            acc_q   <= s_bit;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (startBit) begin
            abort_q <= 1'b1;
            data_q  <= firstWord;
            count_q <= CNT_W'(1);
            acc_q   <= s_bit;
          end else if (s_valid) begin
            data_q  <= data_q | bitMask;
            acc_q   <= acc_q ^ s_bit;
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(DATA_W - 1)) begin
              state_q <= PARITY;
            end
          end
        end
        PARITY: begin
          if (startBit) begin
            abort_q <= 1'b1;
            data_q  <= firstWord;
            count_q <= CNT_W'(1);
            acc_q   <= s_bit;
            state_q <= DATA;
          end else if (s_valid) begin
            parityErr_q <= (acc_q ^ s_bit) != ODD_BIT;
            outValid_q  <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            outValid_q  <= 1'b0;
            parityErr_q <= 1'b0;
            // A start bit on the hand-off cycle opens the next frame immediately.
            if (startBit) begin
              data_q  <= firstWord;
              count_q <= CNT_W'(1);
              acc_q   <= s_bit;
              state_q <= DATA;
            end else begin
              count_q <= '0;
              acc_q   <= 1'b0;
              state_q <= IDLE;
            end
          end else if (s_valid) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid      = outValid_q;
  assign out_data       = data_q;
  assign out_parity_err = parityErr_q;
  assign abort          = abort_q;
  assign overrun        = overrun_q;

endmodule : parity_checker_rx

// File: tb/tb_parity_checker_rx.sv
// Bench for parity_checker_rx: an even and an odd instance share one input
// stream and are compared every cycle against a queue-based frame model.
module tb_parity_checker_rx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, s_valid, s_bit, s_start, out_ready;
  logic         outValid0, outValid1, err0, err1, abort0, abort1, ovr0, ovr1;
  logic [W-1:0] outData0, outData1;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: bits of the frame in progress, plus the held result.
  logic         mBits[$];
  logic         mHeld, mErr0, mErr1, mAbort, mOverrun;
  logic [W-1:0] mData;

  typedef struct {
    logic [W-1:0] data;
    logic         par;
    logic [W-1:0] expData;
    logic         expErrEven;
    logic         expErrOdd;
  } vec_t;

  vec_t vecs[7];

  parity_checker_rx #(.DATA_W(W), .ODD(0)) dutEven (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_start(s_start),
    .out_ready(out_ready), .out_valid(outValid0), .out_data(outData0),
    .out_parity_err(err0), .abort(abort0), .overrun(ovr0)
  );

  parity_checker_rx #(.DATA_W(W), .ODD(1)) dutOdd (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_bit(s_bit), .s_start(s_start),
    .out_ready(out_ready), .out_valid(outValid1), .out_data(outData1),
    .out_parity_err(err1), .abort(abort1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] packBits();
    logic [W-1:0] d = '0;
    for (int i = 0; i < mBits.size() && i < W; i++) d[i] = mBits[i];
    return d;
  endfunction

  task automatic modelUpdate(input logic v, input logic st, input logic b, input logic rdy, input logic r);
    logic p;
    mAbort = 1'b0;
    if (r) begin
      mBits.delete();
      mHeld = 0; mErr0 = 0; mErr1 = 0; mOverrun = 0; mData = '0;
    end else if (mHeld) begin
      if (rdy) begin
        mHeld = 0; mErr0 = 0; mErr1 = 0;
        if (v && st) begin
          mBits.push_back(b);
          mData = packBits();
        end
      end else if (v) begin
        mOverrun = 1'b1;
      end
    end else if (v && st) begin
      if (mBits.size() > 0) mAbort = 1'b1;
      mBits.delete();
      mBits.push_back(b);
      mData = packBits();
    end else if (v && mBits.size() > 0) begin
      mBits.push_back(b);
      mData = packBits();
      if (mBits.size() == W + 1) begin
        p = 1'b0;
        foreach (mBits[i]) p ^= mBits[i];
        mErr0 = (p != 1'b0);
        mErr1 = (p != 1'b1);
        mHeld = 1'b1;
        mBits.delete();
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("valid_even", 32'(outValid0), 32'(mHeld));
    checkOutput("valid_odd",  32'(outValid1), 32'(mHeld));
    checkOutput("data_even",  32'(outData0),  32'(mData));
    checkOutput("data_odd",   32'(outData1),  32'(mData));
    checkOutput("err_even",   32'(err0),      32'(mErr0));
    checkOutput("err_odd",    32'(err1),      32'(mErr1));
    checkOutput("abort_even", 32'(abort0),    32'(mAbort));
    checkOutput("abort_odd",  32'(abort1),    32'(mAbort));
    checkOutput("ovr_even",   32'(ovr0),      32'(mOverrun));
    checkOutput("ovr_odd",    32'(ovr1),      32'(mOverrun));
  endtask

  task automatic applyStimulus(input logic v, input logic st, input logic b, input logic rdy, input logic r);
    @(negedge clk);
    s_valid = v; s_start = st; s_bit = b; out_ready = rdy; rst = r;
    @(posedge clk);
    modelUpdate(v, st, b, rdy, r);
    #1;
    checkAll();
  endtask

  task automatic sendFrame(input logic [W-1:0] d, input logic par, input logic firstReady);
    applyStimulus(1'b1, 1'b1, d[0], firstReady, 1'b0);
    for (int i = 1; i < W; i++) applyStimulus(1'b1, 1'b0, d[i], 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, par, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic checkHeld(input string name, input logic [W-1:0] d, input logic e0, input logic e1);
    checkOutput({name, "_valid"}, 32'(outValid0 & outValid1), 32'd1);
    checkOutput({name, "_data"},  32'(outData0), 32'(d));
    checkOutput({name, "_err_e"}, 32'(err0), 32'(e0));
    checkOutput({name, "_err_o"}, 32'(err1), 32'(e1));
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_start = 1'b0; out_ready = 1'b0;
    mBits.delete();
    mHeld = 0; mErr0 = 0; mErr1 = 0; mAbort = 0; mOverrun = 0; mData = '0;

    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 8'h81, 1'b1, 1'b0};

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_outputs", 32'({outValid0, outData0, err0, abort0, ovr0}), 32'd0);

    for (int i = 0; i < 7; i++) begin
      sendFrame(vecs[i].data, vecs[i].par, 1'b0);
      checkHeld("table", vecs[i].expData, vecs[i].expErrEven, vecs[i].expErrOdd);
      idle(1'b1);
      checkOutput("table_released", 32'(outValid0), 32'd0);
      idle(1'b0);
    end

    // Restart after four data bits must pulse abort exactly once.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("abort_pulse", 32'(abort0), 32'd1);
    for (int i = 1; i < W; i++) begin
      applyStimulus(1'b1, 1'b0, i inside {2, 3, 4, 5}, 1'b0, 1'b0);
      if (i == 1) checkOutput("abort_single", 32'(abort0), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkHeld("abort_frame", 8'h3C, 1'b0, 1'b1);
    idle(1'b1);

    sendFrame(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("overrun_set", 32'(ovr0), 32'd1);
    checkHeld("overrun_hold", 8'hA5, 1'b0, 1'b1);
    idle(1'b1);
    checkOutput("overrun_release", 32'(outValid0), 32'd0);
    checkOutput("overrun_sticky", 32'(ovr0), 32'd1);

    sendFrame(8'hFF, 1'b0, 1'b0);
    checkHeld("b2b_first", 8'hFF, 1'b0, 1'b1);
    sendFrame(8'h00, 1'b0, 1'b1);
    checkHeld("b2b_second", 8'h00, 1'b0, 1'b1);
    idle(1'b1);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("midreset_outputs", 32'({outValid0, outData0, err0, abort0, ovr0}), 32'd0);
    sendFrame(8'h81, 1'b0, 1'b0);
    checkHeld("after_reset", 8'h81, 1'b0, 1'b1);
    idle(1'b1);

    for (int n = 0; n < 4000; n++) begin
      applyStimulus(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 11) == 0),
                    1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_parity_checker_rx

// File: doc/parity_checker_rx.md
PARITY_CHECKER_RX -- requirements
Module: parity_checker_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (range 2..32).
REQ-002 SHALL have parameter ODD, default 0, meaning 0 = even parity (data XOR parity = 0), 1 = odd parity (data XOR parity = 1).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset; synchronous and active-high.
REQ-005 SHALL have port s_valid  input  1  meaning s_bit is valid this cycle.
REQ-006 SHALL have port s_bit  input  1  meaning the serial bit; data LSB first, then the parity bit.
REQ-007 SHALL have port s_start  input  1  meaning the first data bit of a frame, qualified by s_valid.
REQ-008 SHALL have port out_ready  input  1  meaning the consumer accepts the frame.
REQ-009 SHALL have port out_valid  output  1  meaning a frame result is held.
REQ-010 SHALL have port out_data  output  DATA_W  meaning the received data word.
REQ-011 SHALL have port out_parity_err  output  1  meaning a parity mismatch on the held frame.
REQ-012 SHALL have port abort  output  1  meaning a one-cycle pulse when a partial frame is discarded.
REQ-013 SHALL have port overrun  output  1  meaning a sticky flag: a bit arrived while a result was held.

Function
REQ-014 SHALL implement states IDLE, DATA, PARITY and HOLD.
REQ-015 SHALL ignore s_valid in IDLE unless s_start=1; on s_valid&s_start it SHALL load bit 0, set count=1 and the running XOR to s_bit, and go to DATA.
REQ-016 SHALL, in DATA, on each s_valid, store s_bit at index count, XOR it into the accumulator and increment count; it SHALL go to PARITY after bit DATA_W-1 is stored.
REQ-017 SHALL, in PARITY, on s_valid, set out_parity_err = (acc ^ s_bit) != ODD and go to HOLD; out_valid SHALL assert the cycle after the parity bit is sampled.
REQ-018 SHALL keep out_valid, out_data and out_parity_err stable in HOLD until out_valid&out_ready, then return to IDLE.
REQ-019 SHALL, on a HOLD-exit cycle with s_valid&s_start, begin a new frame in the same cycle (enter DATA, no lost bit).
REQ-020 SHALL, in HOLD without exit, on s_valid, drop the bit and set overrun; overrun SHALL clear only on reset.
REQ-021 SHALL, on s_valid&s_start in DATA or PARITY, pulse abort for one cycle and restart with that bit as data bit 0.
REQ-022 SHALL keep state, count and accumulator unchanged on cycles with s_valid=0; gaps of any length are legal.
REQ-023 SHALL size count as clog2(DATA_W+1) bits and never let it exceed DATA_W.
REQ-024 SHALL keep abort low outside its pulse and keep out_valid low outside HOLD.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, go to IDLE and clear count, the accumulator, out_data, out_valid, out_parity_err, abort and overrun to 0.
REQ-026 SHALL discard any partial frame on reset mid-frame without an abort pulse.
REQ-027 SHALL give rst priority over all other inputs in the same cycle.

Structure
REQ-028 SHALL take the state enum and the PARITY_EVEN=0 and PARITY_ODD=1 constants from the shared package parity_pkg.
REQ-029 SHALL keep the shift, count and XOR datapath inline; no sub-module is required.
REQ-030 SHALL register all outputs, with no combinational path from inputs to outputs.

Verification
REQ-031 SHALL cover: DATA_W=8, ODD=0, send 0xA5 then parity 0 -> out_valid, out_data=0xA5, out_parity_err=0.
REQ-032 SHALL cover: same frame with parity 1 -> out_data=0xA5, out_parity_err=1; ODD=1 with 0x01 and parity 0 -> err=0.
REQ-033 SHALL cover: s_start after 4 data bits -> abort pulses 1 cycle; the new frame 0x3C with parity 0 returns 0x3C, err=0.
REQ-034 SHALL cover: hold out_ready=0 and send 3 bits -> overrun=1 and the held 0xA5 is unchanged; the out_ready pulse then returns to IDLE.
REQ-035 SHALL cover: out_ready=1 with s_start in the same cycle -> back-to-back frames 0xFF and 0x00 both delivered, err=0.
REQ-036 SHALL cover: rst asserted at bit 5 -> all outputs 0 next cycle; the next full frame 0x81 decodes correctly.
